// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debounce front end.
//   db_state_t              per-bit debounce FSM state
//   SW_SYNC_STAGES_DEF      default synchronizer depth
//   SW_DEBOUNCE_CYCLES_DEF  default persistence window (10 ms at 50 MHz)
//   db_cnt_width()          settle counter width for a given window
package sw_debounce_pkg;

  localparam int unsigned SW_SYNC_STAGES_DEF     = 2;
  localparam int unsigned SW_DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [0:0] {
    DB_IDLE   = 1'b0,
    DB_SETTLE = 1'b1
  } db_state_t;

  // Counter only has to reach cycles-1, so $clog2(cycles) bits are enough;
  // clamp to one bit so a degenerate window still elaborates.
  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit conditioning path: multi-flop synchronizer followed by a
// persistence counter and a two-state FSM that accepts a new level only
// after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   sw_raw     raw switch pin, asynchronous to clk
//   sw_stable  debounced level (registered)
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = db_cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_sync;

  db_state_t              state_q;
  db_state_t              state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   stable_q;
  logic                   stable_nxt;

  logic                   differ;
  logic                   cnt_done;

  // Synchronizer shift register; the last stage feeds the debouncer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sw_sync  = sync_q[SYNC_STAGES-1];
  assign differ   = sw_sync ^ stable_q;
  assign cnt_done = (cnt_q == CNT_MAX);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DB_IDLE: begin
        if (differ) begin
          state_d = DB_SETTLE;
        end
      end
      DB_SETTLE: begin
        // Either the glitch went away or the new level has persisted long enough.
        if (!differ || cnt_done) begin
          state_d = DB_IDLE;
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  // Counter / level update. The cycle spent in IDLE that first sees the
  // mismatch counts as the first persistence cycle, hence the load of 1 on
  // entry; acceptance happens when the counter sits at CNT_MAX and the
  // mismatch is still present, giving exactly DEBOUNCE_CYCLES mismatch cycles.
  always_comb begin
    cnt_d      = '0;
    stable_nxt = stable_q;
    case (state_q)
      DB_IDLE: begin
        if (differ) begin
          cnt_d = CNT_W'(1);
        end
      end
      DB_SETTLE: begin
        if (differ) begin
          if (cnt_done) begin
            stable_nxt = sw_sync;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        cnt_d      = '0;
        stable_nxt = stable_q;
      end
    endcase
  end

  // Counter and accepted level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_nxt;
    end
  end

  assign sw_stable = stable_q;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning front end for the HPS switch PIO: per-bit synchronizer
// and debouncer, registered rise/fall pulses, and an optional sticky
// edge-capture register with an interrupt line.
// Build option: define SW_DEBOUNCE_EDGE_IRQ_EN to include edge_capture/irq;
// when undefined both outputs are tied low and edge_clear is ignored.
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   sw_raw        raw switch pins, asynchronous to clk
//   sw_stable     debounced levels, to the PIO in_port
//   sw_rise       one-cycle pulse per bit on a 0->1 of sw_stable
//   sw_fall       one-cycle pulse per bit on a 1->0 of sw_stable
//   edge_clear    write-one-to-clear strobe for edge_capture
//   edge_capture  sticky per-bit edge flags
//   irq           OR of all edge_capture bits (registered)
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = SW_SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  localparam int unsigned CNT_W = db_cnt_width(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] sw_stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // One independent debouncer per switch bit.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .sw_raw    (sw_raw[g]),
      .sw_stable (stable_w[g])
    );
  end

  // Delayed level and registered edge pulses (one cycle after the level moves).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_stable_d <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
    end else begin
      sw_stable_d <= stable_w;
      rise_q      <= stable_w & ~sw_stable_d;
      fall_q      <= ~stable_w & sw_stable_d;
    end
  end

  assign sw_stable = stable_w;
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;

`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic             irq_q;

  // Sticky flags: a new edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    cap_d = (cap_q & ~edge_clear) | rise_q | fall_q;
  end

  // irq follows the next value so it moves on the same edge as the flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      irq_q <= |cap_d;
    end
  end

  assign edge_capture = cap_q;
  assign irq          = irq_q;
`else
  logic unused_edge_clear;

  assign unused_edge_clear = ^edge_clear;
  assign edge_capture      = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=8, SYNC_STAGES=2:
// a vector table for the main flow plus hand sequences for the quiet period,
// bounce rejection and reset during settling.
module tb_sw_debounce;

  localparam int unsigned WIDTH = 4;

`ifdef SW_DEBOUNCE_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] edge_capture;
  logic             irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  raw;
    logic [3:0]  clr;
    int unsigned cycles;
    logic [3:0]  st;
    logic [3:0]  ri;
    logic [3:0]  fa;
    logic [3:0]  cap;
    logic        irq;
  } vec_t;

  vec_t vecs[21];

  sw_debounce #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_raw       (sw_raw),
    .sw_stable    (sw_stable),
    .sw_rise      (sw_rise),
    .sw_fall      (sw_fall),
    .edge_clear   (edge_clear),
    .edge_capture (edge_capture),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] st, input logic [3:0] ri,
                       input logic [3:0] fa, input logic [3:0] cap, input logic irq_e);
    logic [3:0] cap_x;
    logic       irq_x;
    cap_x = EDGE_EN ? cap : 4'b0000;
    irq_x = EDGE_EN ? irq_e : 1'b0;
    n_vec++;
    if ({sw_stable, sw_rise, sw_fall, edge_capture, irq} !== {st, ri, fa, cap_x, irq_x}) begin
      n_err++;
      $display("FAIL %s: got stable=%b rise=%b fall=%b cap=%b irq=%b, want stable=%b rise=%b fall=%b cap=%b irq=%b",
               name, sw_stable, sw_rise, sw_fall, edge_capture, irq, st, ri, fa, cap_x, irq_x);
    end
  endtask

  initial begin
    // raw, clr, cycles, stable, rise, fall, cap, irq
    // Clean step on bit 0: level at edge 10, rise at 11, capture at 12.
    vecs[0]  = '{4'b0001, 4'b0000, 9,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0001, 4'b0000, 1,  4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[4]  = '{4'b0001, 4'b0000, 5,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    // 7-cycle glitch on bit 1 is rejected.
    vecs[5]  = '{4'b0011, 4'b0000, 7,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[6]  = '{4'b0001, 4'b0000, 20, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    // 8-cycle pulse on bit 1 is accepted, then falls 10 edges after raw drops.
    vecs[7]  = '{4'b0011, 4'b0000, 8,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[8]  = '{4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[9]  = '{4'b0001, 4'b0000, 1,  4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b1};
    vecs[10] = '{4'b0001, 4'b0000, 1,  4'b0011, 4'b0010, 4'b0000, 4'b0001, 1'b1};
    vecs[11] = '{4'b0001, 4'b0000, 1,  4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    vecs[12] = '{4'b0001, 4'b0000, 5,  4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    vecs[13] = '{4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    vecs[14] = '{4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 4'b0010, 4'b0011, 1'b1};
    vecs[15] = '{4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    // Bit 0 falls; clear coincides with the fall capture, set wins.
    vecs[16] = '{4'b0000, 4'b0000, 10, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    vecs[17] = '{4'b0000, 4'b0000, 1,  4'b0000, 4'b0000, 4'b0001, 4'b0011, 1'b1};
    vecs[18] = '{4'b0000, 4'b0001, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1};
    // Clears alone take effect on the next edge, irq drops with the last flag.
    vecs[19] = '{4'b0000, 4'b0001, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1};
    vecs[20] = '{4'b0000, 4'b0010, 1,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    reset      = 1'b1;
    sw_raw     = '0;
    edge_clear = '0;
    tick(3);
    check("in_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;

    // Quiet period after reset with all pins low.
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check($sformatf("quiet%0d", i), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    for (int i = 0; i < 21; i++) begin
      sw_raw     = vecs[i].raw;
      edge_clear = vecs[i].clr;
      tick(1);
      edge_clear = '0;
      if (vecs[i].cycles > 1) tick(vecs[i].cycles - 1);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ri, vecs[i].fa, vecs[i].cap, vecs[i].irq);
    end

    // Bit 2 bounces every 3 cycles for 30 cycles; nothing may get through.
    for (int i = 0; i < 10; i++) begin
      sw_raw = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int k = 0; k < 3; k++) begin
        tick(1);
        check($sformatf("bounce%0d_%0d", i, k), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end
    end
    sw_raw = 4'b0100;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check($sformatf("bounce_hold%0d", k), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(1);
    check("bounce_level", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check("bounce_rise", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check($sformatf("bounce_after%0d", k), 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    end

    // Reset while bit 3 is settling (counter at 5).
    sw_raw = 4'b1100;
    tick(7);
    #2 reset = 1'b1;
    #1 check("reset_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check($sformatf("post_reset%0d", k), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick(1);
    check("post_reset_level", 4'b1100, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check("post_reset_rise", 4'b1100, 4'b1100, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check("post_reset_cap", 4'b1100, 4'b0000, 4'b0000, 4'b1100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
